vram_arbiter: RTL and testbench

Shares one single-port video RAM between the display scan-out fetcher and two pixel writers (game-logic clients).
- Display reads always win.
- Writers are served round-robin, and only while the sync block reports blanking.
- The block sits between the 800x600 sync/pixel pipeline and the frame/tile RAM.
- All RAM command outputs are registered.

---
 rtl/vram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Arbitrates one single-port, write-first video RAM between the display
//   scan-out fetcher and two pixel writers. Display reads always win; writers
//   are served round-robin with bounded bursts, and only while blank=1.
//   All RAM command outputs and grants are registered.
//
// Optional build macro: VRAM_STATS_EN
//   Defined   -> stall_cnt counts cycles where a writer requests but is not
//                granted (saturating at 16'hFFFF).
//   Undefined -> stall_cnt is tied to 0.
//
// Ports:
//   clk, w_rst_n           clock, asynchronous active-low reset
//   blank                  1 = display outside active area, writes allowed
//   disp_req/disp_addr     display read request (one word per cycle)
//   disp_valid/disp_rdata  read return, 2 cycles after disp_req is sampled
//   wrN_req/addr/data      writer N request, held until granted
//   wrN_gnt                one-cycle pulse: writer N write issued
//   mem_en/we/addr/wdata   registered RAM command
//   mem_rdata              RAM read data, 1 cycle after a read command
//   stall_cnt              writer stall counter (see macro above)
module vram_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          w_rst_n,
  input  logic          blank,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [DW-1:0] disp_rdata,
  input  logic          wr0_req,
  input  logic [AW-1:0] wr0_addr,
  input  logic [DW-1:0] wr0_data,
  output logic          wr0_gnt,
  input  logic          wr1_req,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  output logic          wr1_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t     state, state_nx;
  logic       rr_ptr, rr_nx;
  logic [3:0] burst_cnt, burst_nx;
  logic       g0, g1;
  logic [1:0] rd_tag;

  // Writer selection. Evaluated only when the display is idle and blank=1;
  // otherwise state and burst count are frozen and no grant is issued.
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    burst_nx = burst_cnt;
    g0       = 1'b0;
    g1       = 1'b0;
    if (!disp_req && blank) begin
      case (state)
        IDLE: begin
          if (wr0_req && (!wr1_req || !rr_ptr)) begin
            g0 = 1'b1; state_nx = OWN0; burst_nx = 4'd1;
          end else if (wr1_req) begin
            g1 = 1'b1; state_nx = OWN1; burst_nx = 4'd1;
          end
        end
        OWN0: begin
          if (wr0_req && (!wr1_req || burst_cnt < BMAX)) begin
            g0 = 1'b1;
            burst_nx = (burst_cnt < BMAX) ? burst_cnt + 4'd1 : burst_cnt;
          end else if (wr1_req) begin
            g1 = 1'b1; state_nx = OWN1; burst_nx = 4'd1; rr_nx = 1'b0;
          end else begin
            state_nx = IDLE; rr_nx = 1'b0;
          end
        end
        OWN1: begin
          if (wr1_req && (!wr0_req || burst_cnt < BMAX)) begin
            g1 = 1'b1;
            burst_nx = (burst_cnt < BMAX) ? burst_cnt + 4'd1 : burst_cnt;
          end else if (wr0_req) begin
            g0 = 1'b1; state_nx = OWN0; burst_nx = 4'd1; rr_nx = 1'b1;
          end else begin
            state_nx = IDLE; rr_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
      rd_tag    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr0_gnt   <= 1'b0;
      wr1_gnt   <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      burst_cnt <= burst_nx;
      rd_tag    <= {rd_tag[0], disp_req};
      wr0_gnt   <= g0;
      wr1_gnt   <= g1;
      if (disp_req) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= disp_addr;
      end else if (g0) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wr0_addr;
        mem_wdata <= wr0_data;
      end else if (g1) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wr1_addr;
        mem_wdata <= wr1_data;
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

  // Second tag stage lines up with the RAM's registered read data, so the
  // return path passes mem_rdata through, masked to 0 when not valid.
  assign disp_valid = rd_tag[1];
  assign disp_rdata = rd_tag[1] ? mem_rdata : '0;

`ifdef VRAM_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)
      stall_q <= '0;
    else if ((wr0_req || wr1_req) && !(g0 || g1) && (stall_q != '1))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural write-first RAM and
// a read-return scoreboard (expected data pushed when a read is driven).
module tb_vram_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
`ifdef VRAM_STATS_EN
  localparam int STALL_EXP = 10;
`else
  localparam int STALL_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          w_rst_n;
  logic          blank;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_rdata;
  logic          wr0_req;
  logic [AW-1:0] wr0_addr;
  logic [DW-1:0] wr0_data;
  logic          wr0_gnt;
  logic          wr1_req;
  logic [AW-1:0] wr1_addr;
  logic [DW-1:0] wr1_data;
  logic          wr1_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(4)) dut (
    .clk(clk), .w_rst_n(w_rst_n), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  // Write-first synchronous RAM, preloaded (lazily) with pat().
  logic [7:0] ram [logic [15:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] = mem_wdata;
        mem_rdata <= mem_wdata;
      end else begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : pat(mem_addr);
      end
    end
  end

  // Bench-side record of what each address should hold.
  logic [7:0] shadow [logic [15:0]];
  function automatic logic [7:0] expect_rd(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : pat(a);
  endfunction

  typedef struct { int due; logic [7:0] data; } rd_t;
  rd_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_issue(input logic [15:0] a);
    rd_t e;
    disp_req  = 1'b1;
    disp_addr = a;
    e.due  = cyc + 2;
    e.data = expect_rd(a);
    sb.push_back(e);
  endtask

  // Read-return monitor: every disp_valid must match the oldest expected
  // read in cycle and data; an expected read that never shows is flagged.
  always @(negedge clk) begin
    rd_t e;
    if (w_rst_n) begin
      if (disp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(disp_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("rd_latency", 32'(cyc), 32'(e.due));
          chk("rd_data", 32'(disp_rdata), 32'(e.data));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rd_missing", 32'(disp_valid), 32'(1));
      end
    end
  end

  initial begin
    w_rst_n = 1'b0; blank = 1'b0;
    disp_req = 1'b0; disp_addr = '0;
    wr0_req = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_req = 1'b0; wr1_addr = '0; wr1_data = '0;
    tick; tick;

    // Reset state
    chk("rst_en",    32'(mem_en), 32'(0));
    chk("rst_we",    32'(mem_we), 32'(0));
    chk("rst_addr",  32'(mem_addr), 32'(0));
    chk("rst_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_gnt",   32'({wr1_gnt, wr0_gnt}), 32'(0));
    chk("rst_valid", 32'({disp_valid, disp_rdata}), 32'(0));
    chk("rst_stall", 32'(stall_cnt), 32'(0));

    // Round robin with bursts of 4 from reset
    w_rst_n = 1'b1; blank = 1'b1;
    wr0_req = 1'b1; wr0_addr = 16'h2000; wr0_data = 8'h11;
    wr1_req = 1'b1; wr1_addr = 16'h2001; wr1_data = 8'h22;
    for (int i = 0; i < 9; i++) begin
      tick;
      chk($sformatf("rr_grant%0d", i), 32'({wr1_gnt, wr0_gnt}),
          (i >= 4 && i < 8) ? 32'(2) : 32'(1));
      if (i == 4) begin
        chk("rr_addr1",  32'(mem_addr), 32'h2001);
        chk("rr_wdata1", 32'(mem_wdata), 32'h22);
      end
    end
    shadow[16'h2000] = 8'h11;
    shadow[16'h2001] = 8'h22;
    wr0_req = 1'b0; wr1_req = 1'b0;
    tick;

    // Reset mid-burst with a read in flight
    wr0_req = 1'b1; wr0_addr = 16'h3000; wr0_data = 8'h33;
    tick;
    chk("mb_gnt", 32'(wr0_gnt), 32'(1));
    shadow[16'h3000] = 8'h33;
    disp_req = 1'b1; disp_addr = 16'h0020;
    tick;
    w_rst_n = 1'b0;
    #1;
    chk("mb_rst_cmd", 32'({mem_en, mem_we}), 32'(0));
    chk("mb_rst_addr", 32'(mem_addr), 32'(0));
    chk("mb_rst_gnt", 32'({wr1_gnt, wr0_gnt}), 32'(0));
    disp_req = 1'b0; wr0_req = 1'b0;
    tick; tick;
    w_rst_n = 1'b1;
    tick; tick;

    // First read after reset
    rd_issue(16'h0010);
    tick;
    disp_req = 1'b0;
    chk("post_rst_v1", 32'(disp_valid), 32'(0));
    tick;
    chk("post_rst_v2", 32'(disp_valid), 32'(1));
    chk("post_rst_d", 32'(disp_rdata), 32'(expect_rd(16'h0010)));

    // Display priority over a waiting writer
    blank = 1'b1;
    wr0_req = 1'b1; wr0_addr = 16'h0300; wr0_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      rd_issue(16'h0040 + 16'(i));
      tick;
      chk($sformatf("pri_gnt%0d", i), 32'(wr0_gnt), 32'(0));
      chk($sformatf("pri_rd%0d", i), 32'({mem_en, mem_we, mem_addr}),
          32'({1'b1, 1'b0, 16'h0040 + 16'(i)}));
    end
    disp_req = 1'b0;
    tick;
    chk("pri_gnt_after", 32'(wr0_gnt), 32'(1));
    chk("pri_wr_cmd", 32'({mem_we, mem_addr}), 32'({1'b1, 16'h0300}));
    shadow[16'h0300] = 8'h77;
    wr0_req = 1'b0;
    tick;

    // blank falling mid-burst: registered write completes, nothing more
    wr0_req = 1'b1; wr0_addr = 16'h0400; wr0_data = 8'h44;
    tick;
    chk("bf_gnt1", 32'(wr0_gnt), 32'(1));
    shadow[16'h0400] = 8'h44;
    blank = 1'b0;
    tick;
    chk("bf_gnt0", 32'(wr0_gnt), 32'(0));
    chk("bf_en", 32'(mem_en), 32'(0));
    wr0_req = 1'b0;
    rd_issue(16'h0400);
    tick;
    disp_req = 1'b0;
    tick; tick;

    // Stall counter: 10 blocked cycles from a fresh reset
    w_rst_n = 1'b0;
    tick;
    w_rst_n = 1'b1; blank = 1'b0;
    wr0_req = 1'b1; wr0_addr = 16'h0500; wr0_data = 8'h55;
    repeat (10) tick;
    chk("stall_cnt", 32'(stall_cnt), 32'(STALL_EXP));
    wr0_req = 1'b0;

    // Blank gating for writer 1
    wr1_req = 1'b1; wr1_addr = 16'h1234; wr1_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("bg_blocked%0d", i), 32'({wr1_gnt, mem_en}), 32'(0));
    end
    blank = 1'b1;
    tick;
    chk("bg_gnt", 32'(wr1_gnt), 32'(1));
    chk("bg_cmd", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 16'h1234, 8'h5A}));
    shadow[16'h1234] = 8'h5A;
    wr1_req = 1'b0;
    tick;
    chk("bg_pulse", 32'(wr1_gnt), 32'(0));

    // Write then immediately read the same address
    wr0_req = 1'b1; wr0_addr = 16'h0100; wr0_data = 8'hA5;
    tick;
    chk("raw_gnt", 32'(wr0_gnt), 32'(1));
    wr0_req = 1'b0;
    shadow[16'h0100] = 8'hA5;
    rd_issue(16'h0100);
    tick;
    disp_req = 1'b0;
    tick;
    chk("raw_valid", 32'(disp_valid), 32'(1));
    chk("raw_data", 32'(disp_rdata), 32'hA5);

    // Back-to-back reads, including previously written addresses
    rd_issue(16'h1234); tick;
    rd_issue(16'h2001); tick;
    for (int i = 0; i < 6; i++) begin
      rd_issue(16'($urandom_range(0, 16'hFFFF)));
      tick;
    end
    disp_req = 1'b0;
    repeat (4) tick;
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
